fabric_egress_buffer: RTL and testbench
=======================================

Name: fabric_egress_buffer

Overview:
- Per-output-port stage directly downstream of the switch fabric crossbar; one instance per physical egress port (1G or 10G).
- Snoops the crossbar channel feeding its port group and accepts frames addressed to its own port ID.
- Applies VLAN egress filtering, the fabric's outstanding VLAN TODO.
- Stores accepted frames in a store-and-forward buffer with commit/rollback, then presents whole frames to the transmit MAC over a valid/ready stream.

Parameters:
- PORT_ID, 0, fabric port number of this egress port (port_t, 0..27).
- DEPTH, 512, buffer depth in 64-bit words; power of two, at least 256.
- CNT_WIDTH, 32, width of the drop counters.

Ports:
- clk  in  1  fabric clock, 156.25 MHz.
- rst_n  in  1  synchronous active-low reset.
- chan_valid  in  1  crossbar channel data valid; high for the whole frame, low between frames.
- chan_dest_port  in  5  destination port_t of the current channel frame.
- chan_src_port  in  5  source port_t of the current channel frame.
- chan_vlan  in  12  vlan_t of the frame.
- chan_bytes_valid  in  4  valid bytes (1..8); meaningful on the last word only.
- chan_data  in  64  frame data.
- cfg_vlan  in  12  access VLAN of this port.
- cfg_trunk  in  1  1 = accept every VLAN.
- tx_valid  out  1  output word valid.
- tx_ready  in  1  MAC accepts the word.
- tx_data  out  64  output data.
- tx_bytes_valid  out  4  valid bytes; 8 on every non-last word.
- tx_last  out  1  last word of the frame.
- drop_vlan_count  out  CNT_WIDTH  frames dropped by the VLAN filter; saturating.
- drop_ovf_count  out  CNT_WIDTH  frames dropped by buffer overflow; saturating.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0; wr_ptr = commit_ptr = rd_ptr = 0; frame_count = 0; hold register empty; write FSM enters SYNC.
- Write FSM states: SYNC, IDLE, ACCEPT, DROP.
- SYNC: wait for chan_valid low, then go to IDLE. This prevents capturing a frame that was already in flight when reset released.
- IDLE, on chan_valid rising:
  - If chan_dest_port != PORT_ID, go to DROP with no count.
  - If chan_src_port == PORT_ID (hairpin), go to DROP with no count.
  - If !cfg_trunk && chan_vlan != cfg_vlan, go to DROP and increment drop_vlan_count.
  - Otherwise go to ACCEPT and latch the first word into the hold register.
- Filtering is evaluated only on the first word. cfg_* changes mid-frame do not affect the current frame.
- ACCEPT, each valid word:
  - The previous held word is written to RAM at wr_ptr with last=0, bytes=8; wr_ptr++.
  - The new word is latched into the hold register.
- ACCEPT, chan_valid falling:
  - The held word is written with last=1 and the bytes_valid latched with it; wr_ptr++; commit_ptr <= wr_ptr+1; frame_count++.
  - The next state is IDLE.
- Word-count rule: a frame of N words occupies N RAM entries; commit occurs 1 cycle after chan_valid falls.
- Overflow: if a RAM write would make wr_ptr+1 == rd_ptr (full), abort:
  - wr_ptr <= commit_ptr; drop_ovf_count++.
  - Go to DROP; nothing partial becomes visible.
- DROP: ignore words until chan_valid is low, then go to IDLE. A chan_valid low cycle in IDLE and a new rising edge on the next cycle must be handled back-to-back.
- Pointer width: log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Pointers wrap modulo DEPTH.
- RAM storage per entry: 64 data bits, 4 bytes_valid bits, 1 last bit. The RAM is simple dual-port with 1-cycle read latency.
- Read side: a frame is eligible when frame_count > 0. Words are prefetched so that tx_valid holds a word from rd_ptr < commit_ptr.
- Read-side handshake:
  - tx_* are registered outputs; a 2-entry skid buffer absorbs the RAM latency.
  - While tx_valid && !tx_ready, all tx_* outputs are stable.
  - Transfer occurs on tx_valid && tx_ready.
  - Sustained throughput is 1 word/clk when tx_ready is held high.
- frame_count decrements on a transfer with tx_last. Simultaneous commit and last-transfer in the same cycle leaves frame_count unchanged.
- Only committed words are read; the read side never passes commit_ptr.
- Latency: the first tx word is valid no earlier than 3 cycles after the commit edge (write, read, register).
- Counters saturate at all-ones and are cleared only by reset.

Decomposition:
- port_t, vlan_t, and the constant MAX_FRAME_WORDS = 190 come from the shared SwitchFabric.svh package.
- Add an egress_word_t struct (data, bytes_valid, last) to that package.
- One sub-module, fabric_egress_ram: parameterised simple dual-port RAM of egress_word_t with 1-cycle read, inferable as block RAM.

Test Plan:
1. Unicast accept: PORT_ID=3, cfg_vlan=10, one 8-word frame with dest=3, vlan=10, last bytes_valid=5. Required: tx emits exactly 8 words, tx_last on word 8 with bytes_valid=5, data matches; drop counters stay 0.
2. Filtering: frame with vlan=20 and cfg_trunk=0 gives drop_vlan_count=1 and no tx. The same frame with cfg_trunk=1 is emitted. A frame with dest=4 is silently ignored, as is one with src=3.
3. Overflow: DEPTH=256, tx_ready=0, four 64-word frames sent back-to-back. Required: the first three frames commit; the fourth is rolled back and drop_ovf_count=1. After tx_ready=1, exactly 192 words come out, the last one on a frame boundary.
4. Backpressure: random tx_ready at 50% over 20 frames of random length 8..190. Required: in-order, lossless output; tx_* stable while stalled.
5. Back-to-back input: two 1-word frames separated by a single idle cycle. Required: two tx frames, each a single word with tx_last=1; frame_count returns to 0.
6. Reset mid-frame: assert rst_n=0 during word 5 of a 10-word frame, release while chan_valid is still high. Required: the remainder is ignored (SYNC), tx_valid=0, and the next frame is accepted normally.

Source files
------------

// File: rtl/fabric_egress_buffer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fabric_egress_buffer_pkg
//  Description : Shared switch-fabric types plus the egress buffer word format
//                and write-side state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fabric_egress_buffer_pkg;

  // Fabric-wide identifiers
  typedef logic [4:0]  port_t;
  typedef logic [11:0] vlan_t;

  // Largest frame the fabric will ever carry, in 64-bit words
  localparam int MAX_FRAME_WORDS = 190;

  // Byte count carried by every word that is not the last of its frame
  localparam logic [3:0] C_FULL_BYTES = 4'd8;

  // One buffer entry: payload, valid byte count, end-of-frame marker
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  bytes_valid;
    logic        last;
  } egress_word_t;

  // Write-side frame capture states
  typedef enum logic [1:0] {
    WR_SYNC   = 2'd0,
    WR_IDLE   = 2'd1,
    WR_ACCEPT = 2'd2,
    WR_DROP   = 2'd3
  } wr_state_t;

endpackage : fabric_egress_buffer_pkg
`default_nettype wire

// File: rtl/fabric_egress_buffer_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fabric_egress_ram
//  Description : Simple dual-port RAM of egress_word_t, one write port and one
//                registered read port (1-cycle latency), block-RAM inferable.
//  Revision    : 1.0 - initial release
// ============================================================================
module fabric_egress_ram
  import fabric_egress_buffer_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  egress_word_t             i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output egress_word_t             o_rd_data
);

  egress_word_t r_mem [DEPTH];
  egress_word_t r_rd_data;

  // Storage array is left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : fabric_egress_ram
`default_nettype wire

// File: rtl/fabric_egress_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fabric_egress_buffer
//  Description : Per-port egress stage. Snoops the crossbar channel, keeps
//                frames for PORT_ID that pass VLAN filtering, stores them in a
//                store-and-forward buffer with commit/rollback and streams
//                whole frames to the transmit MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module fabric_egress_buffer
  import fabric_egress_buffer_pkg::*;
#(
  parameter port_t PORT_ID   = 5'd0,
  parameter int    DEPTH     = 512,
  parameter int    CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chan_valid,
  input  port_t                chan_dest_port,
  input  port_t                chan_src_port,
  input  vlan_t                chan_vlan,
  input  logic [3:0]           chan_bytes_valid,
  input  logic [63:0]          chan_data,
  input  vlan_t                cfg_vlan,
  input  logic                 cfg_trunk,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [63:0]          tx_data,
  output logic [3:0]           tx_bytes_valid,
  output logic                 tx_last,
  output logic [CNT_WIDTH-1:0] drop_vlan_count,
  output logic [CNT_WIDTH-1:0] drop_ovf_count
);

  localparam int C_ADDR_W = $clog2(DEPTH);
  localparam int C_PTR_W  = C_ADDR_W + 1;
  // One slot is kept free so the pointer pair never has to express a full ring
  localparam logic [C_PTR_W-1:0] C_FULL_LEVEL = C_PTR_W'(DEPTH - 1);

  // ---------------- write side ----------------
  wr_state_t            r_wr_state;
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_commit_ptr;
  logic [63:0]          r_hold_data;
  logic [3:0]           r_hold_bytes;
  logic [CNT_WIDTH-1:0] r_drop_vlan;
  logic [CNT_WIDTH-1:0] r_drop_ovf;

  logic                 w_wr_req;
  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_ovf;
  logic                 w_commit;
  egress_word_t         w_wr_word;

  // ---------------- read side ----------------
  logic [C_PTR_W-1:0]   r_rd_ptr;      // released by MAC transfers
  logic [C_PTR_W-1:0]   r_fetch_ptr;   // next RAM address to prefetch
  logic [C_PTR_W-1:0]   r_frame_count;
  logic                 r_rd_pending;
  egress_word_t         r_skid [2];
  logic [1:0]           r_skid_cnt;
  logic                 r_tx_valid;
  egress_word_t         r_tx_word;

  egress_word_t         w_ram_rd;
  logic                 w_fire;
  logic                 w_fire_last;
  logic [2:0]           w_occ;
  logic                 w_rd_en;
  logic                 w_skid_push;
  logic                 w_skid_pop;

  // Every ACCEPT cycle retires the held word; a full buffer turns it into a rollback
  always_comb begin
    w_wr_req              = (r_wr_state == WR_ACCEPT);
    w_full                = ((r_wr_ptr - r_rd_ptr) == C_FULL_LEVEL);
    w_wr_en               = w_wr_req && !w_full;
    w_ovf                 = w_wr_req && w_full;
    w_commit              = w_wr_en && !chan_valid;
    w_wr_word.data        = r_hold_data;
    w_wr_word.bytes_valid = chan_valid ? C_FULL_BYTES : r_hold_bytes;
    w_wr_word.last        = !chan_valid;
  end

  // Frame capture FSM: filter on the first word, hold one word, commit on the falling edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state   <= WR_SYNC;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_hold_data  <= '0;
      r_hold_bytes <= '0;
      r_drop_vlan  <= '0;
      r_drop_ovf   <= '0;
    end else begin
      unique case (r_wr_state)
        WR_SYNC: begin
          if (!chan_valid) r_wr_state <= WR_IDLE;
        end
        WR_IDLE: begin
          if (chan_valid) begin
            if ((chan_dest_port != PORT_ID) || (chan_src_port == PORT_ID)) begin
              r_wr_state <= WR_DROP;
            end else if (!cfg_trunk && (chan_vlan != cfg_vlan)) begin
              r_wr_state <= WR_DROP;
              if (r_drop_vlan != '1) r_drop_vlan <= r_drop_vlan + 1'b1;
            end else begin
              r_wr_state   <= WR_ACCEPT;
              r_hold_data  <= chan_data;
              r_hold_bytes <= chan_bytes_valid;
            end
          end
        end
        WR_ACCEPT: begin
          if (w_ovf) begin
            r_wr_ptr   <= r_commit_ptr;
            if (r_drop_ovf != '1) r_drop_ovf <= r_drop_ovf + 1'b1;
            // A rollback on the closing cycle can go straight to IDLE so a
            // back-to-back frame is not missed
            r_wr_state <= chan_valid ? WR_DROP : WR_IDLE;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (chan_valid) begin
              r_hold_data  <= chan_data;
              r_hold_bytes <= chan_bytes_valid;
            end else begin
              r_commit_ptr <= r_wr_ptr + 1'b1;
              r_wr_state   <= WR_IDLE;
            end
          end
        end
        WR_DROP: begin
          if (!chan_valid) r_wr_state <= WR_IDLE;
        end
        default: r_wr_state <= WR_SYNC;
      endcase
    end
  end

  fabric_egress_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[C_ADDR_W-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_fetch_ptr[C_ADDR_W-1:0]),
    .o_rd_data (w_ram_rd)
  );

  // Prefetch keeps at most three words in flight (tx register, skid, RAM read)
  always_comb begin
    w_fire      = r_tx_valid && tx_ready;
    w_fire_last = w_fire && r_tx_word.last;
    w_occ       = 3'(r_skid_cnt) + 3'(r_rd_pending) + 3'(r_tx_valid);
    w_rd_en     = (r_fetch_ptr != r_commit_ptr) && (r_frame_count != '0) &&
                  ((w_occ < 3'd3) || w_fire);
    w_skid_push = r_rd_pending;
    w_skid_pop  = (r_skid_cnt != 2'd0) && (!r_tx_valid || w_fire);
  end

  // Two-entry skid buffer absorbing RAM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
      r_skid_cnt <= 2'd0;
    end else begin
      unique case ({w_skid_push, w_skid_pop})
        2'b10: begin
          r_skid[r_skid_cnt[0]] <= w_ram_rd;
          r_skid_cnt            <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid[0]  <= r_skid[1];
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid[0] <= w_ram_rd;
          end else begin
            r_skid[0] <= r_skid[1];
            r_skid[1] <= w_ram_rd;
          end
        end
        default: ;
      endcase
    end
  end

  // Read pointers and registered tx word; tx holds steady until the MAC takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_fetch_ptr  <= '0;
      r_rd_pending <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_word    <= '0;
    end else begin
      r_rd_pending <= w_rd_en;
      if (w_rd_en) r_fetch_ptr <= r_fetch_ptr + 1'b1;
      if (w_fire)  r_rd_ptr    <= r_rd_ptr + 1'b1;
      if (w_skid_pop) begin
        r_tx_valid <= 1'b1;
        r_tx_word  <= r_skid[0];
      end else if (w_fire) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  // Committed-but-unsent frame tally; a same-cycle commit and last transfer cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_count <= '0;
    end else begin
      unique case ({w_commit, w_fire_last})
        2'b10:   r_frame_count <= r_frame_count + 1'b1;
        2'b01:   r_frame_count <= r_frame_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign tx_valid        = r_tx_valid;
  assign tx_data         = r_tx_word.data;
  assign tx_bytes_valid  = r_tx_word.bytes_valid;
  assign tx_last         = r_tx_word.last;
  assign drop_vlan_count = r_drop_vlan;
  assign drop_ovf_count  = r_drop_ovf;

endmodule : fabric_egress_buffer
`default_nettype wire

// File: tb/tb_fabric_egress_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fabric_egress_buffer
//  Description : Self-checking bench for fabric_egress_buffer with a queue
//                based reference model of accepted frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_egress_buffer;
  import fabric_egress_buffer_pkg::*;

  localparam int         DEPTH   = 256;
  localparam int         CAP     = DEPTH - 1;
  localparam logic [4:0] MY_PORT = 5'd3;

  logic        clk;
  logic        rst_n;
  logic        chan_valid;
  logic [4:0]  chan_dest_port;
  logic [4:0]  chan_src_port;
  logic [11:0] chan_vlan;
  logic [3:0]  chan_bytes_valid;
  logic [63:0] chan_data;
  logic [11:0] cfg_vlan;
  logic        cfg_trunk;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_data;
  logic [3:0]  tx_bytes_valid;
  logic        tx_last;
  logic [31:0] drop_vlan_count;
  logic [31:0] drop_ovf_count;

  fabric_egress_buffer #(
    .PORT_ID   (MY_PORT),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .chan_valid       (chan_valid),
    .chan_dest_port   (chan_dest_port),
    .chan_src_port    (chan_src_port),
    .chan_vlan        (chan_vlan),
    .chan_bytes_valid (chan_bytes_valid),
    .chan_data        (chan_data),
    .cfg_vlan         (cfg_vlan),
    .cfg_trunk        (cfg_trunk),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .tx_bytes_valid   (tx_bytes_valid),
    .tx_last          (tx_last),
    .drop_vlan_count  (drop_vlan_count),
    .drop_ovf_count   (drop_ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          xfer_cnt   = 0;
  logic        last_seen_last  = 1'b0;
  logic [3:0]  last_seen_bytes = 4'd0;
  int          exp_vlan   = 0;
  int          exp_ovf    = 0;
  int          ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // MAC ready pattern
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every transfer against the model, every stall for stability
  initial begin
    logic        stall_prev;
    logic [63:0] sd;
    logic [5:0]  sc;
    exp_t        e;
    stall_prev = 1'b0;
    sd = '0;
    sc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_data", tx_data, sd);
          chk("stall_ctl", 64'({tx_valid, tx_bytes_valid, tx_last}), 64'(sc));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %0h expected no word", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e.d);
            chk("tx_ctl", 64'({tx_bytes_valid, tx_last}), 64'({e.b, e.l}));
          end
          xfer_cnt++;
          last_seen_last  = tx_last;
          last_seen_bytes = tx_bytes_valid;
        end
        stall_prev = tx_valid && !tx_ready;
        sd = tx_data;
        sc = {tx_valid, tx_bytes_valid, tx_last};
      end
    end
  end

  // Drive one frame; the model decides acceptance from the filtering and capacity rules
  task automatic send_frame(input logic [4:0] dest, input logic [4:0] src,
                            input logic [11:0] vlan, input int n,
                            input logic [3:0] lb, input int rst_at);
    logic [63:0] words[$];
    bit   route_ok, vlan_ok, accept;
    exp_t e;
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
    route_ok = (dest == MY_PORT) && (src != MY_PORT);
    vlan_ok  = cfg_trunk || (vlan == cfg_vlan);
    accept   = route_ok && vlan_ok && (exp_q.size() + n <= CAP);
    if (route_ok && !vlan_ok) exp_vlan++;
    else if (route_ok && vlan_ok && !accept) exp_ovf++;
    if (accept) begin
      for (int i = 0; i < n; i++) begin
        e.d = words[i];
        e.b = (i == n - 1) ? lb : 4'd8;
        e.l = (i == n - 1);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      tick;
      rst_n            = 1'b1;
      chan_valid       = 1'b1;
      chan_dest_port   = dest;
      chan_src_port    = src;
      chan_vlan        = vlan;
      chan_data        = words[i];
      chan_bytes_valid = (i == n - 1) ? lb : 4'($urandom_range(1, 8));
      if (rst_at > 0 && i == rst_at - 1) begin
        rst_n = 1'b0;
        exp_q.delete();
        exp_vlan = 0;
        exp_ovf  = 0;
      end
    end
    tick;
    rst_n      = 1'b1;
    chan_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick;
      c++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (4) tick;
    chk("idle_after_drain", 64'(tx_valid), 64'd0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_vlan_cnt"}, 64'(drop_vlan_count), 64'(exp_vlan));
    chk({tag, "_ovf_cnt"},  64'(drop_ovf_count),  64'(exp_ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    chan_valid = 1'b0;
    chan_dest_port = '0;
    chan_src_port = '0;
    chan_vlan = '0;
    chan_bytes_valid = '0;
    chan_data = '0;
    cfg_vlan = 12'd10;
    cfg_trunk = 1'b0;
    ready_mode = 1;
    repeat (3) tick;

    // Reset state
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_tx_ctl", 64'({tx_bytes_valid, tx_last}), 64'd0);
    chk("rst_vlan_cnt", 64'(drop_vlan_count), 64'd0);
    chk("rst_ovf_cnt", 64'(drop_ovf_count), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick;

    // Unicast accept: 8 words, last carries 5 bytes
    xfer_cnt = 0;
    send_frame(5'd3, 5'd7, 12'd10, 8, 4'd5, 0);
    drain(200);
    chk("t1_words", 64'(xfer_cnt), 64'd8);
    chk("t1_last_bytes", 64'(last_seen_bytes), 64'd5);
    chk("t1_last_flag", 64'(last_seen_last), 64'd1);
    check_counts("t1");

    // Filtering: VLAN drop, trunk accept, wrong destination, hairpin
    xfer_cnt = 0;
    send_frame(5'd3, 5'd1, 12'd20, 6, 4'd3, 0);
    cfg_trunk = 1'b1;
    send_frame(5'd3, 5'd1, 12'd20, 6, 4'd3, 0);
    cfg_trunk = 1'b0;
    send_frame(5'd4, 5'd1, 12'd10, 5, 4'd8, 0);
    send_frame(5'd3, 5'd3, 12'd10, 5, 4'd8, 0);
    drain(200);
    chk("t2_words", 64'(xfer_cnt), 64'd6);
    chk("t2_vlan_drop_lit", 64'(drop_vlan_count), 64'd1);
    check_counts("t2");

    // Overflow: MAC stalled, four 64-word frames, fourth must roll back
    ready_mode = 0;
    repeat (2) tick;
    xfer_cnt = 0;
    for (int f = 0; f < 4; f++) send_frame(5'd3, 5'd9, 12'd10, 64, 4'($urandom_range(1, 8)), 0);
    repeat (6) tick;
    chk("t3_ovf_lit", 64'(drop_ovf_count), 64'd1);
    check_counts("t3");
    ready_mode = 1;
    drain(600);
    chk("t3_words", 64'(xfer_cnt), 64'd192);
    chk("t3_frame_boundary", 64'(last_seen_last), 64'd1);

    // Backpressure: random ready, random lengths, occasional filtered frames
    ready_mode = 2;
    for (int f = 0; f < 20; f++) begin
      int n;
      int c;
      n = $urandom_range(8, 190);
      c = 0;
      while ((exp_q.size() + n > CAP - 8) && c < 2000) begin
        tick;
        c++;
      end
      send_frame(($urandom_range(0, 5) == 0) ? 5'd4 : 5'd3, 5'd12,
                 ($urandom_range(0, 5) == 0) ? 12'd11 : 12'd10,
                 n, 4'($urandom_range(1, 8)), 0);
    end
    ready_mode = 1;
    drain(3000);
    check_counts("t4");

    // Back-to-back single-word frames separated by one idle cycle
    xfer_cnt = 0;
    send_frame(5'd3, 5'd2, 12'd10, 1, 4'd2, 0);
    send_frame(5'd3, 5'd2, 12'd10, 1, 4'd7, 0);
    drain(100);
    chk("t5_words", 64'(xfer_cnt), 64'd2);
    chk("t5_last_flag", 64'(last_seen_last), 64'd1);
    chk("t5_frame_count", 64'(dut.r_frame_count), 64'd0);

    // Reset during word 5 of a 10-word frame, released with the channel still busy
    xfer_cnt = 0;
    send_frame(5'd3, 5'd2, 12'd10, 10, 4'd4, 5);
    repeat (6) tick;
    chk("t6_no_tx", 64'(tx_valid), 64'd0);
    chk("t6_words_none", 64'(xfer_cnt), 64'd0);
    send_frame(5'd3, 5'd2, 12'd10, 3, 4'd6, 0);
    drain(100);
    chk("t6_words", 64'(xfer_cnt), 64'd3);
    chk("t6_vlan_cnt_lit", 64'(drop_vlan_count), 64'd0);
    check_counts("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_fabric_egress_buffer
`default_nettype wire
